ext_point_feeder: RTL and testbench
===================================

EXT_POINT_FEEDER -- requirements
Module: ext_point_feeder

Interface
REQ-001 SHALL have no parameters; clock i_SYSTEM_clk only; reset i_SYSTEM_rst is synchronous, active-high.
REQ-002 i_SYSTEM_clk  in  1  sole clock, all logic on rising edge.
REQ-003 i_SYSTEM_rst  in  1  synchronous active-high reset.
REQ-004 CTRL_start  in  1  one-cycle pulse, begins a frame (ignored unless IDLE).
REQ-005 CTRL_PCSize  in  19  point count, sampled on accepted CTRL_start.
REQ-006 CTRL_done  out  1  one-cycle pulse at frame end.
REQ-007 CTRL_status  out  32  [2:0] state, [3] read-ID error, [4] write-ID error, [31:5] 0.
REQ-008 MEM_rdReq  out  1  one-cycle point-memory read strobe.
REQ-009 MEM_rdAddr  out  19  read address (point index).
REQ-010 MEM_rdValid  in  1  read data valid, latency >=1 cycle.
REQ-011 MEM_rdData  in  64  {custom[63:48], Z[47:32], Y[31:16], X[15:0]}.
REQ-012 MEM_wrEn  out  1  one-cycle custom-field write strobe.
REQ-013 MEM_wrAddr  out  19  write address (point index).
REQ-014 MEM_wrData  out  16  custom field to store.
REQ-015 EXT_enable  out  1  frame active toward extension.
REQ-016 EXT_PCSize  out  19  latched point count.
REQ-017 EXT_readReady  in  1  extension requests point EXT_readID.
REQ-018 EXT_readID  in  19  requested point index.
REQ-019 EXT_readValid  out  1  point data valid.
REQ-020 EXT_pointX / EXT_pointY / EXT_pointZ  out  16 each  point coordinates.
REQ-021 EXT_readCustomField  out  16  stored custom field of point.
REQ-022 EXT_writeValid  in  1  extension offers result.
REQ-023 EXT_writeID  in  19  result point index.
REQ-024 EXT_writeCustomField  in  16  result value.
REQ-025 EXT_writeReady  out  1  feeder can accept result.
REQ-026 EXT_doneProcessing  in  1  extension finished frame.

Function
REQ-027 Read FSM states SHALL be IDLE=0, WAIT_REQ=1, FETCH=2, PRESENT=3, RELEASE=4, DONE=5; CTRL_status[2:0] = current state.
REQ-028 IDLE: on CTRL_start latch CTRL_PCSize into EXT_PCSize, clear status[4:3], set EXT_enable=1 next cycle, go WAIT_REQ.
REQ-029 WAIT_REQ: EXT_doneProcessing=1 has priority -> DONE; else EXT_readReady=1 with EXT_readID<PCSize -> MEM_rdReq=1, MEM_rdAddr=EXT_readID for one cycle, go FETCH; EXT_readID>=PCSize -> set status[3] sticky, stay WAIT_REQ, no memory access.
REQ-030 FETCH: on MEM_rdValid register X/Y/Z/custom onto EXT_point*/EXT_readCustomField, EXT_readValid=1 next cycle, go PRESENT; MEM_rdValid outside FETCH ignored.
REQ-031 PRESENT: hold data and EXT_readValid=1 until EXT_readValid&&EXT_readReady, then EXT_readValid=0 next cycle, go RELEASE; data stable while valid.
REQ-032 RELEASE: wait until EXT_readReady=0 (extension ready is registered, stays high >=1 extra cycle), then WAIT_REQ; prevents duplicate fetch.
REQ-033 DONE: EXT_enable=0, CTRL_done=1 for exactly one cycle, then IDLE; EXT_PCSize retained.
REQ-034 Write channel independent FSM W_READY/W_LOW: EXT_writeReady=1 in W_READY while EXT_enable=1; on EXT_writeValid&&EXT_writeReady with EXT_writeID<PCSize pulse MEM_wrEn, MEM_wrAddr=EXT_writeID, MEM_wrData=EXT_writeCustomField next cycle; ID>=PCSize sets status[4] sticky, no write; either case EXT_writeReady=0, go W_LOW.
REQ-035 W_LOW: return to W_READY once EXT_writeValid=0; each extension write produces exactly one MEM_wrEn.
REQ-036 Simultaneous accepted read and write in same cycle SHALL both be serviced; memory read and write ports independent.
REQ-037 EXT_doneProcessing in FETCH/PRESENT/RELEASE SHALL be ignored until WAIT_REQ; PCSize=0 frame: any read request sets error, done still completes frame.

Reset
REQ-038 While i_SYSTEM_rst=1 at a clock edge: both FSMs to IDLE/W_READY, all outputs 0 (EXT_enable, EXT_readValid, EXT_writeReady, MEM_rdReq, MEM_wrEn, CTRL_done, data/address/PCSize regs, status), including mid-frame; pending memory read data discarded.

Verification
REQ-039 Start PCSize=3, dummy-style extension reads IDs 0,1,2 with rdData latency 2 -> three MEM_rdReq at addr 0,1,2, matching EXT_point* values, three MEM_wrEn, one CTRL_done.
REQ-040 EXT_readReady held 2 cycles past handshake -> exactly one MEM_rdReq per point; EXT_writeValid held 1 cycle past handshake -> exactly one MEM_wrEn.
REQ-041 PCSize=4, EXT_readID=4 -> no MEM_rdReq, CTRL_status[3]=1; EXT_writeID=7 -> no MEM_wrEn, CTRL_status[4]=1.
REQ-042 Read handshake and write handshake in same cycle -> both MEM_rdReq (prior) and MEM_wrEn issued, no loss.
REQ-043 Assert i_SYSTEM_rst during PRESENT -> next cycle all outputs 0, state 0; late MEM_rdValid ignored; new CTRL_start then runs normally.

Source files
------------

// File: rtl/ext_point_feeder_if.sv
// ----------------------------------------------------------------------------
// ext_point_feeder_if
//
// Purpose : bundles every non-clock/reset signal of the point feeder into one
//           interface so the feeder and its environment share one definition.
//
// Signal groups
//   CTRL_*  frame control: start pulse, point count, done pulse, status word
//   MEM_*   point memory: read strobe/address, read data return,
//           custom-field write strobe/address/data
//   EXT_*   extension: frame enable, point count, point read channel
//           (ready/ID in, valid/data out), result write channel
//           (valid/ID/data in, ready out), end-of-frame indication
//
// Modports
//   master  the feeder itself
//   slave   the environment (controller, memory and extension)
// ----------------------------------------------------------------------------
interface ext_point_feeder_if;
    // Control
    logic        CTRL_start;
    logic [18:0] CTRL_PCSize;
    logic        CTRL_done;
    logic [31:0] CTRL_status;

    // Point memory
    logic        MEM_rdReq;
    logic [18:0] MEM_rdAddr;
    logic        MEM_rdValid;
    logic [63:0] MEM_rdData;
    logic        MEM_wrEn;
    logic [18:0] MEM_wrAddr;
    logic [15:0] MEM_wrData;

    // Extension
    logic        EXT_enable;
    logic [18:0] EXT_PCSize;
    logic        EXT_readReady;
    logic [18:0] EXT_readID;
    logic        EXT_readValid;
    logic [15:0] EXT_pointX;
    logic [15:0] EXT_pointY;
    logic [15:0] EXT_pointZ;
    logic [15:0] EXT_readCustomField;
    logic        EXT_writeValid;
    logic [18:0] EXT_writeID;
    logic [15:0] EXT_writeCustomField;
    logic        EXT_writeReady;
    logic        EXT_doneProcessing;

    modport master (
        input  CTRL_start, CTRL_PCSize,
        output CTRL_done, CTRL_status,
        output MEM_rdReq, MEM_rdAddr,
        input  MEM_rdValid, MEM_rdData,
        output MEM_wrEn, MEM_wrAddr, MEM_wrData,
        output EXT_enable, EXT_PCSize,
        input  EXT_readReady, EXT_readID,
        output EXT_readValid, EXT_pointX, EXT_pointY, EXT_pointZ, EXT_readCustomField,
        input  EXT_writeValid, EXT_writeID, EXT_writeCustomField,
        output EXT_writeReady,
        input  EXT_doneProcessing
    );

    modport slave (
        output CTRL_start, CTRL_PCSize,
        input  CTRL_done, CTRL_status,
        input  MEM_rdReq, MEM_rdAddr,
        output MEM_rdValid, MEM_rdData,
        input  MEM_wrEn, MEM_wrAddr, MEM_wrData,
        input  EXT_enable, EXT_PCSize,
        output EXT_readReady, EXT_readID,
        input  EXT_readValid, EXT_pointX, EXT_pointY, EXT_pointZ, EXT_readCustomField,
        output EXT_writeValid, EXT_writeID, EXT_writeCustomField,
        input  EXT_writeReady,
        output EXT_doneProcessing
    );
endinterface

// File: rtl/ext_point_feeder.sv
// ----------------------------------------------------------------------------
// ext_point_feeder
//
// Purpose : serves point reads from a point memory to a processing extension
//           and writes the extension's per-point result (custom field) back.
//           A read FSM fetches one point per extension request; an independent
//           write FSM turns each extension result into exactly one memory write.
//
// Ports
//   i_SYSTEM_clk  in   sole clock, rising edge
//   i_SYSTEM_rst  in   synchronous active-high reset
//   bus           ext_point_feeder_if.master (control, memory, extension)
//
// Status word: [2:0] read FSM state, [3] read-ID error, [4] write-ID error.
// ----------------------------------------------------------------------------
module ext_point_feeder (
    input logic              i_SYSTEM_clk,
    input logic              i_SYSTEM_rst,
    ext_point_feeder_if.master bus
);

    // Encoding is visible on CTRL_status[2:0], so values are fixed.
    typedef enum logic [2:0] {
        RD_IDLE     = 3'd0,
        RD_WAIT_REQ = 3'd1,
        RD_FETCH    = 3'd2,
        RD_PRESENT  = 3'd3,
        RD_RELEASE  = 3'd4,
        RD_DONE     = 3'd5
    } rd_state_e;

    typedef enum logic {
        W_READY = 1'b0,
        W_LOW   = 1'b1
    } wr_state_e;

    // Read side
    rd_state_e   rd_state_q, rd_state_d;
    logic [18:0] pc_size_q,  pc_size_d;
    logic        enable_q,   enable_d;
    logic        done_q,     done_d;
    logic        rd_req_q,   rd_req_d;
    logic [18:0] rd_addr_q,  rd_addr_d;
    logic        rd_valid_q, rd_valid_d;
    logic [63:0] point_q,    point_d;
    logic        rd_err_q,   rd_err_d;
    logic        clear_wr_err;

    // Write side
    wr_state_e   wr_state_q, wr_state_d;
    logic        wr_en_q,    wr_en_d;
    logic [18:0] wr_addr_q,  wr_addr_d;
    logic [15:0] wr_data_q,  wr_data_d;
    logic        wr_err_q,   wr_err_d;
    logic        write_ready;

    // ------------------------------------------------------------------------
    // Read FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        rd_state_d   = rd_state_q;
        pc_size_d    = pc_size_q;
        enable_d     = enable_q;
        done_d       = 1'b0;
        rd_req_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_valid_d   = rd_valid_q;
        point_d      = point_q;
        rd_err_d     = rd_err_q;
        clear_wr_err = 1'b0;

        case (rd_state_q)
            RD_IDLE: begin
                if (bus.CTRL_start) begin
                    pc_size_d    = bus.CTRL_PCSize;
                    rd_err_d     = 1'b0;
                    clear_wr_err = 1'b1;
                    enable_d     = 1'b1;
                    rd_state_d   = RD_WAIT_REQ;
                end
            end

            RD_WAIT_REQ: begin
                // End of frame wins over a request raised in the same cycle.
                if (bus.EXT_doneProcessing) begin
                    enable_d   = 1'b0;
                    done_d     = 1'b1;
                    rd_state_d = RD_DONE;
                end else if (bus.EXT_readReady) begin
                    if (bus.EXT_readID < pc_size_q) begin
                        rd_req_d   = 1'b1;
                        rd_addr_d  = bus.EXT_readID;
                        rd_state_d = RD_FETCH;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end

            RD_FETCH: begin
                if (bus.MEM_rdValid) begin
                    point_d    = bus.MEM_rdData;
                    rd_valid_d = 1'b1;
                    rd_state_d = RD_PRESENT;
                end
            end

            RD_PRESENT: begin
                if (rd_valid_q && bus.EXT_readReady) begin
                    rd_valid_d = 1'b0;
                    rd_state_d = RD_RELEASE;
                end
            end

            RD_RELEASE: begin
                // The extension's ready is registered and lingers after the
                // handshake; waiting for it to fall avoids a second fetch.
                if (!bus.EXT_readReady) begin
                    rd_state_d = RD_WAIT_REQ;
                end
            end

            RD_DONE: begin
                rd_state_d = RD_IDLE;
            end

            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Write FSM: next state and outputs
    // ------------------------------------------------------------------------
    assign write_ready = (wr_state_q == W_READY) && enable_q;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_err_d   = clear_wr_err ? 1'b0 : wr_err_q;

        case (wr_state_q)
            W_READY: begin
                if (bus.EXT_writeValid && write_ready) begin
                    if (bus.EXT_writeID < pc_size_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = bus.EXT_writeID;
                        wr_data_d = bus.EXT_writeCustomField;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                    wr_state_d = W_LOW;
                end
            end

            W_LOW: begin
                // Holding valid past the handshake must not produce a repeat write.
                if (!bus.EXT_writeValid) begin
                    wr_state_d = W_READY;
                end
            end

            default: begin
                wr_state_d = W_READY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_SYSTEM_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its next value from the same pre-edge snapshot.
        if (i_SYSTEM_rst) begin
            // NOTE: datapath registers are reset too, because every output,
            // including data and address, must read zero out of reset.
            rd_state_q <= RD_IDLE;
            pc_size_q  <= '0;
            enable_q   <= 1'b0;
            done_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            point_q    <= '0;
            rd_err_q   <= 1'b0;
            wr_state_q <= W_READY;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            pc_size_q  <= pc_size_d;
            enable_q   <= enable_d;
            done_q     <= done_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            point_q    <= point_d;
            rd_err_q   <= rd_err_d;
            wr_state_q <= wr_state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.CTRL_done           = done_q;
    assign bus.CTRL_status         = {27'd0, wr_err_q, rd_err_q, rd_state_q};
    assign bus.MEM_rdReq           = rd_req_q;
    assign bus.MEM_rdAddr          = rd_addr_q;
    assign bus.MEM_wrEn            = wr_en_q;
    assign bus.MEM_wrAddr          = wr_addr_q;
    assign bus.MEM_wrData          = wr_data_q;
    assign bus.EXT_enable          = enable_q;
    assign bus.EXT_PCSize          = pc_size_q;
    assign bus.EXT_readValid       = rd_valid_q;
    assign bus.EXT_pointX          = point_q[15:0];
    assign bus.EXT_pointY          = point_q[31:16];
    assign bus.EXT_pointZ          = point_q[47:32];
    assign bus.EXT_readCustomField = point_q[63:48];
    assign bus.EXT_writeReady      = write_ready;

endmodule

// File: tb/tb_ext_point_feeder.sv
// ----------------------------------------------------------------------------
// tb_ext_point_feeder
//
// Drives ext_point_feeder through the slave side of its interface: a point
// memory model with configurable read latency, a dummy-style extension that
// reads points and writes results, and frame control. Expected memory traffic
// is derived from the extension's own requests (ID below the frame's point
// count => exactly one access) and compared against what the DUT issued.
// ----------------------------------------------------------------------------
module tb_ext_point_feeder;

    logic clk = 1'b0;
    logic rst;

    ext_point_feeder_if bus ();

    ext_point_feeder dut (
        .i_SYSTEM_clk (clk),
        .i_SYSTEM_rst (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model and traffic logs
    logic [63:0] mem [0:15];
    int          lat     = 2;
    bit          stray   = 1'b0;
    int          rsp_cnt = 0;
    logic [18:0] rsp_addr;

    logic [18:0] act_rd [$];
    logic [18:0] exp_rd [$];
    logic [34:0] act_wr [$];
    logic [34:0] exp_wr [$];
    int          done_cnt   = 0;
    int          frames_exp = 0;

    logic [18:0] cur_pc;
    bit          exp_rd_err;
    bit          exp_wr_err;

    // Observed memory traffic and done pulses (each a single-cycle strobe).
    always @(negedge clk) begin
        if (bus.MEM_rdReq) act_rd.push_back(bus.MEM_rdAddr);
        if (bus.MEM_wrEn)  act_wr.push_back({bus.MEM_wrAddr, bus.MEM_wrData});
        if (bus.CTRL_done) done_cnt++;
    end

    // Memory read responder: returns mem[addr] 'lat' cycles after the strobe.
    initial begin
        bus.MEM_rdValid = 1'b0;
        bus.MEM_rdData  = '0;
        forever begin
            @(negedge clk);
            bus.MEM_rdValid = stray;
            if (stray) bus.MEM_rdData = 64'h0123_4567_89AB_CDEF;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    bus.MEM_rdValid = 1'b1;
                    bus.MEM_rdData  = mem[rsp_addr[3:0]];
                end
            end
            if (bus.MEM_rdReq) begin
                rsp_cnt  = lat;
                rsp_addr = bus.MEM_rdAddr;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {bus.CTRL_done, bus.CTRL_status, bus.MEM_rdReq, bus.MEM_rdAddr, bus.MEM_wrEn}, 64'd0);
        check({tag, "_wr"}, {bus.MEM_wrAddr, bus.MEM_wrData, bus.EXT_enable, bus.EXT_PCSize, bus.EXT_readValid}, 64'd0);
        check({tag, "_point"}, {bus.EXT_readCustomField, bus.EXT_pointZ, bus.EXT_pointY, bus.EXT_pointX}, 64'd0);
        check({tag, "_wready"}, bus.EXT_writeReady, 1'b0);
    endtask

    task automatic start_frame(input logic [18:0] n);
        @(negedge clk);
        bus.CTRL_start  = 1'b1;
        bus.CTRL_PCSize = n;
        @(negedge clk);
        bus.CTRL_start  = 1'b0;
        bus.CTRL_PCSize = 19'($urandom);
        cur_pc     = n;
        exp_rd_err = 1'b0;
        exp_wr_err = 1'b0;
        check("start_enable", bus.EXT_enable, 1'b1);
        check("start_pcsize", bus.EXT_PCSize, n);
        check("start_state", bus.CTRL_status[4:0], 5'd1);
    endtask

    // Extension read: keep ready high until data arrives, then 'hold' cycles more.
    task automatic ext_read(input logic [18:0] id, input int hold);
        bit ok;
        int c;
        ok = (id < cur_pc);
        @(negedge clk);
        bus.EXT_readReady = 1'b1;
        bus.EXT_readID    = id;
        if (ok) begin
            exp_rd.push_back(id);
            c = 0;
            while (!bus.EXT_readValid && c < 64) begin
                @(negedge clk);
                c++;
            end
            check("rd_timeout", bus.EXT_readValid, 1'b1);
            check("rd_point", {bus.EXT_readCustomField, bus.EXT_pointZ, bus.EXT_pointY, bus.EXT_pointX},
                  mem[id[3:0]]);
            @(negedge clk);
            check("rd_valid_drop", bus.EXT_readValid, 1'b0);
            repeat (hold) @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
            exp_rd_err = 1'b1;
        end
        bus.EXT_readReady = 1'b0;
        check("rd_err", bus.CTRL_status[3], exp_rd_err);
    endtask

    // Extension write: hold valid 'hold' cycles past the handshake.
    task automatic ext_write(input logic [18:0] id, input logic [15:0] val, input int hold);
        int c;
        @(negedge clk);
        bus.EXT_writeValid       = 1'b1;
        bus.EXT_writeID          = id;
        bus.EXT_writeCustomField = val;
        c = 0;
        while (!bus.EXT_writeReady && c < 64) begin
            @(negedge clk);
            c++;
        end
        check("wr_timeout", bus.EXT_writeReady, 1'b1);
        if (id < cur_pc) exp_wr.push_back({id, val});
        else             exp_wr_err = 1'b1;
        repeat (hold + 1) @(negedge clk);
        check("wr_ready_low", bus.EXT_writeReady, 1'b0);
        bus.EXT_writeValid = 1'b0;
        check("wr_err", bus.CTRL_status[4], exp_wr_err);
    endtask

    task automatic compare_traffic();
        check("rd_count", act_rd.size(), exp_rd.size());
        for (int i = 0; i < act_rd.size() && i < exp_rd.size(); i++)
            check("rd_addr", act_rd[i], exp_rd[i]);
        check("wr_count", act_wr.size(), exp_wr.size());
        for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++)
            check("wr_addr_data", act_wr[i], exp_wr[i]);
        act_rd.delete();
        exp_rd.delete();
        act_wr.delete();
        exp_wr.delete();
    endtask

    task automatic end_frame();
        int c;
        @(negedge clk);
        bus.EXT_doneProcessing = 1'b1;
        c = 0;
        while (!bus.CTRL_done && c < 64) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", bus.CTRL_done, 1'b1);
        check("done_state", bus.CTRL_status[2:0], 3'd5);
        check("done_enable", bus.EXT_enable, 1'b0);
        check("done_err_bits", bus.CTRL_status[4:3], {exp_wr_err, exp_rd_err});
        bus.EXT_doneProcessing = 1'b0;
        frames_exp++;
        @(negedge clk);
        check("done_pulse", bus.CTRL_done, 1'b0);
        check("idle_state", bus.CTRL_status[2:0], 3'd0);
        check("pcsize_kept", bus.EXT_PCSize, cur_pc);
        check("done_count", done_cnt, frames_exp);
        compare_traffic();
    endtask

    initial begin
        int c;
        logic [18:0] n, id_r, id_w;

        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};

        rst                      = 1'b1;
        bus.CTRL_start           = 1'b0;
        bus.CTRL_PCSize          = '0;
        bus.EXT_readReady        = 1'b0;
        bus.EXT_readID           = '0;
        bus.EXT_writeValid       = 1'b0;
        bus.EXT_writeID          = '0;
        bus.EXT_writeCustomField = '0;
        bus.EXT_doneProcessing   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Dummy-style frame: points 0..2, latency 2, ready lingers 2 cycles,
        // write valid lingers 1 cycle.
        lat = 2;
        start_frame(19'd3);
        for (int i = 0; i < 3; i++) begin
            ext_read(19'(i), 2);
            ext_write(19'(i), mem[i][15:0] ^ 16'h5A5A, 1);
        end
        end_frame();

        // Out-of-range IDs and a simultaneous read/write handshake.
        start_frame(19'd4);
        ext_read(19'd4, 1);
        ext_write(19'd7, 16'hCAFE, 1);
        fork
            ext_read(19'd1, 1);
            ext_write(19'd2, 16'h1234, 1);
        join
        ext_read(19'd3, 1);
        end_frame();

        // Randomised frames.
        repeat (3) begin
            n = 19'($urandom_range(1, 8));
            start_frame(n);
            repeat (10) begin
                lat  = $urandom_range(1, 3);
                id_r = 19'($urandom_range(0, n + 2));
                id_w = 19'($urandom_range(0, n + 2));
                case ($urandom_range(0, 3))
                    0: ext_read(id_r, $urandom_range(1, 2));
                    1: ext_write(id_w, 16'($urandom), $urandom_range(0, 2));
                    2: fork
                           ext_read(id_r, 1);
                           ext_write(id_w, 16'($urandom), 1);
                       join
                    default: begin
                        ext_read(id_r, 1);
                        ext_write(id_w, 16'($urandom), 0);
                    end
                endcase
            end
            end_frame();
        end

        // Empty frame: every request is out of range, done still ends it.
        start_frame(19'd0);
        ext_read(19'd0, 1);
        ext_write(19'd0, 16'hBEEF, 1);
        end_frame();

        // Reset while presenting a point.
        lat = 2;
        start_frame(19'd5);
        @(negedge clk);
        bus.EXT_readReady = 1'b1;
        bus.EXT_readID    = 19'd2;
        exp_rd.push_back(19'd2);
        c = 0;
        while (!bus.EXT_readValid && c < 64) begin
            @(negedge clk);
            c++;
        end
        check("pre_rst_valid", bus.EXT_readValid, 1'b1);
        bus.EXT_readReady = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midframe_rst");
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_valid_ignored", bus.EXT_readValid, 1'b0);
        check("stray_state", bus.CTRL_status[2:0], 3'd0);
        compare_traffic();

        // Normal operation after reset.
        start_frame(19'd2);
        ext_read(19'd0, 1);
        ext_write(19'd1, 16'h0F0F, 1);
        ext_read(19'd1, 2);
        end_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
